axi_slave_wburst_gen: RTL and testbench

AXI_SLAVE_WBURST_GEN -- requirements
Module: axi_slave_wburst_gen

---
 rtl/axi_slave_wburst_gen.sv | 135 +++++++++++++
 tb/tb_axi_slave_wburst_gen.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_slave_wburst_gen.sv
// AXI4 slave write-burst engine: walks a W burst into a memory port
// and raises a B-channel response request when the burst completes.
module axi_slave_wburst_gen (
  input  logic        clk,
  input  logic        s_axi_aresetn,
  input  logic        aw_start,
  input  logic [31:0] aw_addr,
  input  logic [7:0]  aw_len,
  input  logic [2:0]  aw_size,
  input  logic [1:0]  aw_burst,
  input  logic [11:0] aw_id,
  input  logic        s_axi_wvalid,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_wlast,
  output logic        write_ready,
  input  logic        mem_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  output logic        b_req,
  output logic [11:0] b_id,
  output logic [1:0]  b_resp,
  input  logic        b_done,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    RESP
  } state_t;

  state_t      state;
  logic [31:0] addr_q;
  logic [7:0]  len_q;
  logic [7:0]  cnt_q;
  logic [2:0]  size_q;
  logic [1:0]  burst_q;
  logic [11:0] id_q;
  logic        err_q;

  logic        beat;
  logic        last;
  logic        wrap_ok;
  logic        start_err;
  logic [31:0] bytes;
  logic [31:0] mask;
  logic [31:0] inc;
  logic [31:0] next_addr;

  assign beat    = (state == DATA) & s_axi_wvalid & mem_ready;
  assign last    = (cnt_q == len_q);
  assign bytes   = 32'd1 << size_q;
  assign mask    = ((32'(len_q) + 32'd1) << size_q) - 32'd1;
  assign inc     = addr_q + bytes;
  assign wrap_ok = (len_q == 8'd1) | (len_q == 8'd3)
                 | (len_q == 8'd7) | (len_q == 8'd15);

  // Setup errors that are knowable from the AW fields alone.
  assign start_err = (aw_size > 3'd2)
                   | (aw_burst == 2'b11)
                   | ((aw_burst == 2'b10)
                      & ~((aw_len == 8'd1) | (aw_len == 8'd3)
                        | (aw_len == 8'd7) | (aw_len == 8'd15)));

  // Next beat address; bad WRAP and reserved bursts fall back to INCR.
  always_comb begin
    next_addr = inc;
    unique case (1'b1)
      (burst_q == 2'b00):
        next_addr = addr_q;
      ((burst_q == 2'b10) & wrap_ok):
        next_addr = (addr_q & ~mask) | (inc & mask);
      default:
        next_addr = inc;
    endcase
  end

  assign write_ready = (state == DATA) & mem_ready;
  assign mem_we      = beat & (size_q <= 3'd2);
  assign mem_addr    = addr_q;
  assign mem_wdata   = s_axi_wdata;
  assign mem_wstrb   = s_axi_wstrb;
  assign busy        = (state != IDLE);
  assign b_req       = (state == RESP);
  assign b_id        = id_q;
  assign b_resp      = (b_req & err_q) ? 2'b10 : 2'b00;

  // Burst FSM with latched AW context, beat counter and error flag.
  always_ff @(posedge clk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state   <= IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      id_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (aw_start) begin
            addr_q  <= aw_addr;
            len_q   <= aw_len;
            size_q  <= aw_size;
            burst_q <= aw_burst;
            id_q    <= aw_id;
            cnt_q   <= '0;
            err_q   <= start_err;
            state   <= DATA;
          end
        end
        DATA: begin
          if (beat) begin
            addr_q <= next_addr;
            cnt_q  <= cnt_q + 8'd1;
            if (s_axi_wlast != last)
              err_q <= 1'b1;
            if (last)
              state <= RESP;
          end
        end
        RESP: begin
          if (b_done)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_slave_wburst_gen.sv
// Scoreboard bench for axi_slave_wburst_gen: directed bursts push
// expected writes/responses, a negedge monitor pops and compares.
module tb_axi_slave_wburst_gen;

  logic        clk = 1'b0;
  logic        s_axi_aresetn;
  logic        aw_start;
  logic [31:0] aw_addr;
  logic [7:0]  aw_len;
  logic [2:0]  aw_size;
  logic [1:0]  aw_burst;
  logic [11:0] aw_id;
  logic        s_axi_wvalid;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wlast;
  logic        write_ready;
  logic        mem_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        b_req;
  logic [11:0] b_id;
  logic [1:0]  b_resp;
  logic        b_done;
  logic        busy;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
  } wr_t;

  typedef struct {
    logic [11:0] id;
    logic [1:0]  r;
  } rs_t;

  wr_t wq[$];
  rs_t rq[$];
  int  vec = 0;
  int  miss = 0;
  logic breq_d = 1'b0;

  always #5 clk = ~clk;

  axi_slave_wburst_gen dut (
    .clk          (clk),
    .s_axi_aresetn(s_axi_aresetn),
    .aw_start     (aw_start),
    .aw_addr      (aw_addr),
    .aw_len       (aw_len),
    .aw_size      (aw_size),
    .aw_burst     (aw_burst),
    .aw_id        (aw_id),
    .s_axi_wvalid (s_axi_wvalid),
    .s_axi_wdata  (s_axi_wdata),
    .s_axi_wstrb  (s_axi_wstrb),
    .s_axi_wlast  (s_axi_wlast),
    .write_ready  (write_ready),
    .mem_ready    (mem_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_wstrb    (mem_wstrb),
    .b_req        (b_req),
    .b_id         (b_id),
    .b_resp       (b_resp),
    .b_done       (b_done),
    .busy         (busy)
  );

  function automatic logic [3:0] strb_of(input int i);
    return i[0] ? 4'h3 : 4'hC;
  endfunction

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic exp_wr(input logic [31:0] a, input logic [31:0] db,
                        input int i);
    wr_t e;
    e.a = a;
    e.d = db + 32'(i);
    e.s = strb_of(i);
    wq.push_back(e);
  endtask

  task automatic exp_rs(input logic [11:0] id, input logic [1:0] r);
    rs_t e;
    e.id = id;
    e.r  = r;
    rq.push_back(e);
  endtask

  // Monitor: every memory write and every new response is scored.
  always @(negedge clk) begin
    wr_t w;
    rs_t r;
    if (mem_we) begin
      vec++;
      if (wq.size() == 0) begin
        miss++;
        $display("FAIL unexpected_write: got addr %h data %h, none expected",
                 mem_addr, mem_wdata);
      end else begin
        w = wq.pop_front();
        if (mem_addr !== w.a || mem_wdata !== w.d || mem_wstrb !== w.s) begin
          miss++;
          $display("FAIL write: got %h/%h/%h expected %h/%h/%h",
                   mem_addr, mem_wdata, mem_wstrb, w.a, w.d, w.s);
        end
      end
    end
    if (b_req && !breq_d) begin
      vec++;
      if (rq.size() == 0) begin
        miss++;
        $display("FAIL unexpected_resp: got id %h resp %b, none expected",
                 b_id, b_resp);
      end else begin
        r = rq.pop_front();
        if (b_id !== r.id || b_resp !== r.r) begin
          miss++;
          $display("FAIL resp: got id %h resp %b expected id %h resp %b",
                   b_id, b_resp, r.id, r.r);
        end
      end
    end
    breq_d = b_req;
  end

  task automatic aw(input logic [31:0] a, input logic [7:0] l,
                    input logic [2:0] s, input logic [1:0] b,
                    input logic [11:0] id);
    aw_addr  = a;
    aw_len   = l;
    aw_size  = s;
    aw_burst = b;
    aw_id    = id;
    aw_start = 1'b1;
    @(posedge clk); #1;
    aw_start = 1'b0;
  endtask

  task automatic send(input int n, input logic [31:0] db,
                      input int last_idx, input bit tog);
    int  i = 0;
    int  g = 0;
    bit  ph = 1'b1;
    bit  acc;
    while (i < n && g < 200) begin
      s_axi_wvalid = 1'b1;
      s_axi_wdata  = db + 32'(i);
      s_axi_wstrb  = strb_of(i);
      s_axi_wlast  = (i == last_idx);
      mem_ready    = tog ? ph : 1'b1;
      @(negedge clk);
      if (tog)
        check("ready_mirror", {31'd0, write_ready}, {31'd0, mem_ready});
      acc = write_ready & s_axi_wvalid;
      @(posedge clk); #1;
      if (acc) i++;
      ph = ~ph;
      g++;
    end
    s_axi_wvalid = 1'b0;
    s_axi_wlast  = 1'b0;
    mem_ready    = 1'b1;
    if (g >= 200) begin
      vec++;
      miss++;
      $display("FAIL beat_timeout: got %0d beats expected %0d", i, n);
    end
  endtask

  task automatic resp(input logic [11:0] id, input logic [1:0] r,
                      input int hold, input bit poke);
    int g = 0;
    @(negedge clk);
    while (!b_req && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (!b_req) begin
      vec++;
      miss++;
      $display("FAIL resp_timeout: got no b_req expected id %h", id);
    end
    for (int k = 0; k < hold; k++) begin
      if (k > 0) @(negedge clk);
      check("hold_req", {31'd0, b_req}, 32'd1);
      check("hold_id", {20'd0, b_id}, {20'd0, id});
      check("hold_resp", {30'd0, b_resp}, {30'd0, r});
      if (poke && k == 1) begin
        aw_addr  = 32'hDEAD_0000;
        aw_len   = 8'd0;
        aw_size  = 3'd2;
        aw_burst = 2'b01;
        aw_id    = 12'h555;
        aw_start = 1'b1;
      end
      if (poke && k == 2) aw_start = 1'b0;
    end
    @(posedge clk); #1;
    b_done = 1'b1;
    @(negedge clk);
    check("done_cycle_req", {31'd0, b_req}, 32'd1);
    @(posedge clk); #1;
    b_done = 1'b0;
    @(negedge clk);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_req", {31'd0, b_req}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    s_axi_aresetn = 1'b0;
    aw_start = 1'b0;
    aw_addr = '0;
    aw_len = '0;
    aw_size = '0;
    aw_burst = '0;
    aw_id = '0;
    s_axi_wvalid = 1'b1;
    s_axi_wdata = '0;
    s_axi_wstrb = '0;
    s_axi_wlast = 1'b0;
    mem_ready = 1'b1;
    b_done = 1'b0;
    @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_wready", {31'd0, write_ready}, 32'd0);
    check("rst_we", {31'd0, mem_we}, 32'd0);
    check("rst_breq", {31'd0, b_req}, 32'd0);
    check("rst_bresp", {30'd0, b_resp}, 32'd0);
    check("rst_bid", {20'd0, b_id}, 32'd0);
    s_axi_wvalid = 1'b0;
    @(posedge clk); #1;
    s_axi_aresetn = 1'b1;
    @(posedge clk); #1;

    // INCR
    exp_wr(32'h1000, 32'hA000_0000, 0);
    exp_wr(32'h1004, 32'hA000_0000, 1);
    exp_wr(32'h1008, 32'hA000_0000, 2);
    exp_wr(32'h100C, 32'hA000_0000, 3);
    exp_rs(12'h123, 2'b00);
    aw(32'h1000, 8'd3, 3'd2, 2'b01, 12'h123);
    send(4, 32'hA000_0000, 3, 1'b0);
    resp(12'h123, 2'b00, 1, 1'b0);

    // WRAP
    exp_wr(32'h2038, 32'hB000_0000, 0);
    exp_wr(32'h203C, 32'hB000_0000, 1);
    exp_wr(32'h2030, 32'hB000_0000, 2);
    exp_wr(32'h2034, 32'hB000_0000, 3);
    exp_rs(12'h0AB, 2'b00);
    aw(32'h2038, 8'd3, 3'd2, 2'b10, 12'h0AB);
    send(4, 32'hB000_0000, 3, 1'b0);
    resp(12'h0AB, 2'b00, 1, 1'b0);

    // FIXED with toggling mem_ready
    exp_wr(32'h40, 32'hC000_0000, 0);
    exp_wr(32'h40, 32'hC000_0000, 1);
    exp_wr(32'h40, 32'hC000_0000, 2);
    exp_rs(12'h010, 2'b00);
    aw(32'h40, 8'd2, 3'd2, 2'b00, 12'h010);
    send(3, 32'hC000_0000, 2, 1'b1);
    resp(12'h010, 2'b00, 1, 1'b0);

    // Early wlast
    exp_wr(32'h3000, 32'hD000_0000, 0);
    exp_wr(32'h3004, 32'hD000_0000, 1);
    exp_rs(12'h021, 2'b10);
    aw(32'h3000, 8'd1, 3'd2, 2'b01, 12'h021);
    send(2, 32'hD000_0000, 0, 1'b0);
    resp(12'h021, 2'b10, 1, 1'b0);

    // Oversize beat: no memory writes at all
    exp_rs(12'h032, 2'b10);
    aw(32'h4000, 8'd1, 3'd3, 2'b01, 12'h032);
    send(2, 32'hE000_0000, 1, 1'b0);
    resp(12'h032, 2'b10, 1, 1'b0);

    // WRAP with illegal length falls back to INCR
    exp_wr(32'h7008, 32'h1100_0000, 0);
    exp_wr(32'h700C, 32'h1100_0000, 1);
    exp_wr(32'h7010, 32'h1100_0000, 2);
    exp_rs(12'h043, 2'b10);
    aw(32'h7008, 8'd2, 3'd2, 2'b10, 12'h043);
    send(3, 32'h1100_0000, 2, 1'b0);
    resp(12'h043, 2'b10, 1, 1'b0);

    // Response hold with an ignored aw_start during RESP
    exp_wr(32'h8000, 32'h2200_0000, 0);
    exp_rs(12'hFFF, 2'b00);
    aw(32'h8000, 8'd0, 3'd2, 2'b01, 12'hFFF);
    send(1, 32'h2200_0000, 0, 1'b0);
    resp(12'hFFF, 2'b00, 5, 1'b1);

    // Reset mid-burst
    exp_wr(32'h5000, 32'h3300_0000, 0);
    exp_wr(32'h5004, 32'h3300_0000, 1);
    aw(32'h5000, 8'd7, 3'd2, 2'b01, 12'h066);
    send(2, 32'h3300_0000, -1, 1'b0);
    mem_ready = 1'b1;
    s_axi_aresetn = 1'b0;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_wready", {31'd0, write_ready}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    s_axi_aresetn = 1'b1;
    @(posedge clk); #1;

    // Post-reset INCR crossing the 32-bit boundary
    exp_wr(32'hFFFF_FFFC, 32'h4400_0000, 0);
    exp_wr(32'h0000_0000, 32'h4400_0000, 1);
    exp_rs(12'h007, 2'b00);
    aw(32'hFFFF_FFFC, 8'd1, 3'd2, 2'b01, 12'h007);
    send(2, 32'h4400_0000, 1, 1'b0);
    resp(12'h007, 2'b00, 1, 1'b0);

    repeat (3) @(posedge clk);
    check("wq_drained", 32'(wq.size()), 32'd0);
    check("rq_drained", 32'(rq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
